// File: rtl/div_pkg.sv
// Shared state encodings, counter sizing and result constants for seq_signed_divider.
package div_pkg;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] PREP = 3'd1;
    localparam logic [2:0] ITER = 3'd2;
    localparam logic [2:0] FIX  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    localparam int DEFAULT_WIDTH = 32;
    localparam int CNT_W = $clog2(DEFAULT_WIDTH + 1);

    // A zero divisor yields an all-ones quotient; the remainder echoes the dividend.
    localparam logic DBZ_QUOT_BIT = 1'b1;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring iteration on the {R,Q} shift pair.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   r_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH:0]   diff;
    logic             ge;

    // The full-width compare decides the quotient bit; diff only needs WIDTH+1 bits.
    always_comb begin
        shifted = {r, q[WIDTH-1]};
        ge      = (shifted >= {2'b00, d});
        diff    = shifted[WIDTH:0] - {1'b0, d};
        r_next  = ge ? diff : shifted[WIDTH:0];
        q_next  = {q[WIDTH-2:0], ge};
    end

endmodule

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed restoring divider with valid/ready handshakes on both sides.
// Optional macro DIV_SKIP_ZEROS_EN skips the leading zero bits of |dividend|.
module seq_signed_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [2:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] b_abs_q, b_abs_d;
    logic             a_neg_q, a_neg_d;
    logic             b_neg_q, b_neg_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH:0]   r_step;
    logic [WIDTH-1:0] q_step;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r      (r_q),
        .q      (q_q),
        .d      (b_abs_q),
        .r_next (r_step),
        .q_next (q_step)
    );

`ifdef DIV_SKIP_ZEROS_EN
    logic [CW-1:0] lz;

    always_comb begin
        lz = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (q_q[i]) lz = CW'(WIDTH - 1 - i);
        end
    end
`endif

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        r_d         = r_q;
        q_d         = q_q;
        b_abs_d     = b_abs_q;
        a_neg_d     = a_neg_q;
        b_neg_d     = b_neg_q;
        ovf_pend_d  = ovf_pend_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Magnitudes are unsigned, so |INT_MIN| = 2^(WIDTH-1) is represented exactly.
                    a_neg_d    = dividend[WIDTH-1];
                    b_neg_d    = divisor[WIDTH-1];
                    q_d        = dividend[WIDTH-1] ? -dividend : dividend;
                    b_abs_d    = divisor[WIDTH-1] ? -divisor : divisor;
                    ovf_pend_d = (dividend == INT_MIN) && (divisor == '1);
                    dbz_d      = 1'b0;
                    ovf_d      = 1'b0;
                    state_d    = PREP;
                end
            end
            PREP: begin
                r_d = '0;
                if (b_abs_q == '0) begin
                    state_d = FIX;
                end else begin
`ifdef DIV_SKIP_ZEROS_EN
                    if (q_q == '0) begin
                        state_d = FIX;
                    end else begin
                        q_d     = q_q << lz;
                        cnt_d   = CW'(WIDTH) - lz;
                        state_d = ITER;
                    end
`else
                    cnt_d   = CW'(WIDTH);
                    state_d = ITER;
`endif
                end
            end
            ITER: begin
                r_d   = r_step;
                q_d   = q_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = FIX;
            end
            FIX: begin
                if (b_abs_q == '0) begin
                    quotient_d  = {WIDTH{DBZ_QUOT_BIT}};
                    remainder_d = a_neg_q ? -q_q : q_q;
                    dbz_d       = 1'b1;
                end else begin
                    quotient_d  = (a_neg_q ^ b_neg_q) ? -q_q : q_q;
                    remainder_d = a_neg_q ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];
                    ovf_d       = ovf_pend_q;
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            r_q         <= '0;
            q_q         <= '0;
            b_abs_q     <= '0;
            a_neg_q     <= 1'b0;
            b_neg_q     <= 1'b0;
            ovf_pend_q  <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            r_q         <= r_d;
            q_q         <= q_d;
            b_abs_q     <= b_abs_d;
            a_neg_q     <= a_neg_d;
            b_neg_q     <= b_neg_d;
            ovf_pend_q  <= ovf_pend_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Scoreboard bench for seq_signed_divider: expected results queued at drive time, checked at out_valid.
module tb_seq_signed_divider;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic         ovf;
        int           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    int   tests_run    = 0;
    int   tests_failed = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    seq_signed_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    // Reference arithmetic done in 64-bit signed math, then truncated to W bits.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa;
        longint sb_v;
        logic [W-1:0] mag;
        sa   = longint'($signed(a));
        sb_v = longint'($signed(b));
        mag  = a[W-1] ? (~a + 1'b1) : a;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
            e.ovf = 1'b0;
            e.lat = 2;
        end else begin
            e.q   = W'(sa / sb_v);
            e.r   = W'(sa % sb_v);
            e.dbz = 1'b0;
            e.ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
`ifdef DIV_SKIP_ZEROS_EN
            e.lat = 2;
            for (int i = 0; i < W; i++) if (mag[i]) e.lat = i + 3;
`else
            e.lat = W + 2;
`endif
        end
        return e;
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string name,
                          input int hold, input bit pulse);
        exp_t e;
        int   cycles;
        bit   seen;
        sb.push_back(model(a, b));
        @(negedge clk);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        if (hold > 0) out_ready = 1'b0;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL %s accept_ready: got %b expected 1", name, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 32'h5A5A_5A5A;
        divisor  = 32'h0000_0003;
        cycles   = 0;
        seen     = 1'b0;
        while (!seen && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
            if (pulse && cycles == 5) begin
                tests_run++;
                if (in_ready !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL %s busy_ready: got %b expected 0", name, in_ready);
                end
                in_valid = 1'b1;
            end else if (pulse && cycles == 6) begin
                in_valid = 1'b0;
            end
            if (out_valid === 1'b1) seen = 1'b1;
        end
        in_valid = 1'b0;
        e = sb.pop_front();
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("[TB] FAIL %s timeout: got no out_valid expected one within 200 cycles", name);
            out_ready = 1'b1;
            return;
        end
        if (cycles != e.lat) begin
            tests_failed++;
            $display("[TB] FAIL %s latency: got %0d expected %0d", name, cycles, e.lat);
        end
        tests_run++;
        if (quotient !== e.q) begin
            tests_failed++;
            $display("[TB] FAIL %s quotient: got %h expected %h", name, quotient, e.q);
        end
        tests_run++;
        if (remainder !== e.r) begin
            tests_failed++;
            $display("[TB] FAIL %s remainder: got %h expected %h", name, remainder, e.r);
        end
        tests_run++;
        if ({div_by_zero, overflow} !== {e.dbz, e.ovf}) begin
            tests_failed++;
            $display("[TB] FAIL %s flags: got dbz=%b ovf=%b expected dbz=%b ovf=%b",
                     name, div_by_zero, overflow, e.dbz, e.ovf);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            tests_run++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== e.q || remainder !== e.r) begin
                tests_failed++;
                $display("[TB] FAIL %s hold%0d: got v=%b rdy=%b q=%h r=%h expected v=1 rdy=0 q=%h r=%h",
                         name, i, out_valid, in_ready, quotient, remainder, e.q, e.r);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL %s release: got v=%b rdy=%b expected v=0 rdy=1", name, out_valid, in_ready);
        end
    endtask

    task automatic check_reset_values(input string name);
        tests_run++;
        if ({in_ready, out_valid, div_by_zero, overflow} !== 4'b1000) begin
            tests_failed++;
            $display("[TB] FAIL %s ctrl: got rdy=%b v=%b dbz=%b ovf=%b expected rdy=1 v=0 dbz=0 ovf=0",
                     name, in_ready, out_valid, div_by_zero, overflow);
        end
        tests_run++;
        if (quotient !== '0 || remainder !== '0) begin
            tests_failed++;
            $display("[TB] FAIL %s data: got q=%h r=%h expected 0 0", name, quotient, remainder);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
    endtask

    task automatic test_signs();
        run_op(32'd100, 32'd7, "p100_p7", 0, 1'b0);
        run_op(-32'sd100, 32'd7, "n100_p7", 0, 1'b0);
        run_op(32'd100, -32'sd7, "p100_n7", 0, 1'b0);
        run_op(-32'sd100, -32'sd7, "n100_n7", 0, 1'b0);
        run_op(32'd0, 32'd5, "zero_div", 0, 1'b0);
        run_op(32'd3, 32'd1, "three_by_one", 0, 1'b0);
    endtask

    task automatic test_div_by_zero();
        run_op(32'd7, 32'd0, "dbz_pos", 0, 1'b0);
        run_op(-32'sd5, 32'd0, "dbz_neg", 0, 1'b0);
    endtask

    task automatic test_overflow();
        run_op(32'h8000_0000, 32'hFFFF_FFFF, "intmin_m1", 0, 1'b0);
        run_op(32'h8000_0000, 32'd2, "intmin_2", 0, 1'b0);
        run_op(32'h7FFF_FFFF, 32'h8000_0000, "max_by_min", 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_op(32'd1_000_000, 32'd7, "backpressure", 10, 1'b1);
    endtask

    task automatic test_reset_mid();
        bit saw_valid;
        @(negedge clk);
        dividend = 32'd12345;
        divisor  = 32'd3;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_values("reset_mid");
        @(negedge clk);
        rst_n     = 1'b1;
        saw_valid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid !== 1'b0) saw_valid = 1'b1;
        end
        tests_run++;
        if (saw_valid) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid no_valid: got out_valid=1 expected 0 after reset");
        end
        run_op(32'd1000, 32'd10, "after_reset", 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = W'($urandom_range(1, 1000));
            if ($urandom_range(0, 1) == 1) b = -b;
            if (i == 5) a = a >> 20;
            run_op(a, b, "random", 0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_signs();
        test_div_by_zero();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
